// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing with sprite window hit flag
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int SYNC_POL = 0,
    parameter int POS_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic [POS_W-1:0] win_x,
    input  logic [POS_W-1:0] win_y,
    input  logic [POS_W-1:0] win_w,
    input  logic [POS_W-1:0] win_h,
    output logic [POS_W-1:0] h_pos,
    output logic [POS_W-1:0] v_pos,
    output logic             h_sync,
    output logic             v_sync,
    output logic             active,
    output logic             in_window,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_FP_AT  = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] H_SY_AT  = POS_W'(H_ACTIVE + H_FRONT);
    localparam logic [POS_W-1:0] H_BP_AT  = POS_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [POS_W-1:0] V_FP_AT  = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] V_SY_AT  = POS_W'(V_ACTIVE + V_FRONT);
    localparam logic [POS_W-1:0] V_BP_AT  = POS_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic             SYNC_ON  = (SYNC_POL != 0);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    phase_t h_state, h_state_nxt;
    phase_t v_state, v_state_nxt;

    logic [POS_W-1:0] h_nxt, v_nxt;
    logic             h_wrap, v_wrap;
    logic             line_nxt, frame_nxt;
    logic             active_nxt, in_win_nxt;
    logic [POS_W-1:0] wx, wy, ww, wh;
    logic [POS_W-1:0] wx_nxt, wy_nxt, ww_nxt, wh_nxt;
    logic [POS_W:0]   x_end, y_end;

    function automatic phase_t phase_of(input logic [POS_W-1:0] pos,
                                        input logic [POS_W-1:0] fp_at,
                                        input logic [POS_W-1:0] sy_at,
                                        input logic [POS_W-1:0] bp_at);
        if (pos < fp_at)      return PH_ACTIVE;
        else if (pos < sy_at) return PH_FRONT;
        else if (pos < bp_at) return PH_SYNC;
        else                  return PH_BACK;
    endfunction

    // Next counters, phases, strobes and window hit for the position this edge moves to
    always_comb begin
        h_wrap     = (h_pos == H_LAST);
        v_wrap     = (v_pos == V_LAST);
        h_nxt      = h_pos;
        v_nxt      = v_pos;
        line_nxt   = 1'b0;
        frame_nxt  = 1'b0;
        if (pix_en) begin
            h_nxt    = h_wrap ? '0 : h_pos + 1'b1;
            line_nxt = h_wrap;
            if (h_wrap) begin
                v_nxt     = v_wrap ? '0 : v_pos + 1'b1;
                frame_nxt = v_wrap;
            end
        end
        h_state_nxt = phase_of(h_nxt, H_FP_AT, H_SY_AT, H_BP_AT);
        v_state_nxt = phase_of(v_nxt, V_FP_AT, V_SY_AT, V_BP_AT);
        active_nxt  = (h_state_nxt == PH_ACTIVE) && (v_state_nxt == PH_ACTIVE);
        // the window is captured on the frame_start edge and already applies to (0,0)
        wx_nxt      = frame_nxt ? win_x : wx;
        wy_nxt      = frame_nxt ? win_y : wy;
        ww_nxt      = frame_nxt ? win_w : ww;
        wh_nxt      = frame_nxt ? win_h : wh;
        // one extra bit so windows past the screen edge clip instead of wrapping
        x_end       = {1'b0, wx_nxt} + {1'b0, ww_nxt};
        y_end       = {1'b0, wy_nxt} + {1'b0, wh_nxt};
        in_win_nxt  = active_nxt
                    && (h_nxt >= wx_nxt) && ({1'b0, h_nxt} < x_end)
                    && (v_nxt >= wy_nxt) && ({1'b0, v_nxt} < y_end);
    end

    // Horizontal and vertical phase registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_state <= PH_BACK;
            v_state <= PH_BACK;
        end else begin
            h_state <= h_state_nxt;
            v_state <= v_state_nxt;
        end
    end

    // Counters, registered outputs and latched window, all moving on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_pos       <= H_LAST;
            v_pos       <= V_LAST;
            h_sync      <= ~SYNC_ON;
            v_sync      <= ~SYNC_ON;
            active      <= 1'b0;
            in_window   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            wx          <= '0;
            wy          <= '0;
            ww          <= '0;
            wh          <= '0;
        end else begin
            h_pos       <= h_nxt;
            v_pos       <= v_nxt;
            h_sync      <= (h_state_nxt == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
            v_sync      <= (v_state_nxt == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
            active      <= active_nxt;
            in_window   <= in_win_nxt;
            line_start  <= line_nxt;
            frame_start <= frame_nxt;
            wx          <= wx_nxt;
            wy          <= wy_nxt;
            ww          <= ww_nxt;
            wh          <= wh_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;

    localparam int HA = 32, HF = 4, HS = 6, HB = 6;
    localparam int VA = 20, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 48
    localparam int VT = VA + VF + VS + VB;   // 27
    localparam int PW = 10;

    typedef struct packed {
        logic [PW-1:0] h;
        logic [PW-1:0] v;
        logic hs, vs, act, inw, ls, fs;
    } obs_t;

    typedef struct {
        logic pen;
        obs_t exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pix_en = 1'b0;
    logic [PW-1:0] win_x = '0, win_y = '0, win_w = '0, win_h = '0;
    logic [PW-1:0] h_pos, v_pos;
    logic          h_sync, v_sync, active, in_window, line_start, frame_start;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(0), .POS_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
        .h_pos(h_pos), .v_pos(v_pos), .h_sync(h_sync), .v_sync(v_sync),
        .active(active), .in_window(in_window),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_pass  = 0;
    obs_t sb_q[$];
    obs_t last;
    vec_t tbl[5];

    // reference model state
    int mx, my, mwx, mwy, mww, mwh;
    bit mls, mfs;

    function automatic obs_t mk(int h, int v, bit hs, bit vs, bit act, bit inw, bit ls, bit fs);
        obs_t o;
        o.h = PW'(h); o.v = PW'(v);
        o.hs = hs; o.vs = vs; o.act = act; o.inw = inw; o.ls = ls; o.fs = fs;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(int'(h_pos), int'(v_pos), h_sync, v_sync, active, in_window,
                  line_start, frame_start);
    endfunction

    function automatic obs_t model_obs();
        bit hs, vs, act, inw;
        hs  = !(mx >= HA + HF && mx < HA + HF + HS);
        vs  = !(my >= VA + VF && my < VA + VF + VS);
        act = (mx < HA) && (my < VA);
        inw = act && (mx >= mwx) && (mx < mwx + mww) && (my >= mwy) && (my < mwy + mwh);
        return mk(mx, my, hs, vs, act, inw, mls, mfs);
    endfunction

    task automatic model_reset();
        mx = HT - 1; my = VT - 1;
        mwx = 0; mwy = 0; mww = 0; mwh = 0;
        mls = 0; mfs = 0;
    endtask

    task automatic model_step(input logic pen, output obs_t e);
        bit wrap;
        mls = 0; mfs = 0;
        if (pen) begin
            wrap = (mx == HT - 1);
            mx = wrap ? 0 : mx + 1;
            if (wrap) begin
                mls = 1;
                my = (my == VT - 1) ? 0 : my + 1;
                if (my == 0) begin
                    mfs = 1;
                    mwx = int'(win_x); mwy = int'(win_y);
                    mww = int'(win_w); mwh = int'(win_h);
                end
            end
        end
        e = model_obs();
    endtask

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b act=%b inw=%b ls=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b act=%b inw=%b ls=%b fs=%b",
                      name, got.h, got.v, got.hs, got.vs, got.act, got.inw, got.ls, got.fs,
                      exp.h, exp.v, exp.hs, exp.vs, exp.act, exp.inw, exp.ls, exp.fs);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // drive one clk (called just after an active edge), expected result queued, compared after the edge
    task automatic tick_exp(input string name, input logic pen, input obs_t e);
        obs_t want;
        pix_en = pen;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        last = sample();
        want = sb_q.pop_front();
        check(name, last, want);
    endtask

    task automatic tick(input string name, input logic pen);
        obs_t e;
        model_step(pen, e);
        tick_exp(name, pen, e);
    endtask

    // one full frame of continuous enables starting just after a frame_start
    task automatic run_frame(input string name, input int exp_inw, input int chg_at,
                             input logic [PW-1:0] chg_x);
        int ninw = 0, nact = 0, nvs = 0, nfs = 0;
        for (int i = 0; i < HT * VT; i++) begin
            if (i == chg_at) win_x = chg_x;
            tick(name, 1'b1);
            if (last.inw) ninw++;
            if (last.act) nact++;
            if (!last.vs) nvs++;
            if (last.fs) nfs++;
        end
        check_int({name, "_fs_count"}, nfs, 1);
        check_int({name, "_fs_period"}, int'(last.fs), 1);
        check_int({name, "_active_px"}, nact, HA * VA);
        check_int({name, "_vsync_clks"}, nvs, VS * HT);
        check_int({name, "_window_px"}, ninw, exp_inw);
    endtask

    initial begin
        int nls, nfs, guard;

        tbl[0] = '{pen: 1'b0, exp: mk(HT - 1, VT - 1, 1, 1, 0, 0, 0, 0)};
        tbl[1] = '{pen: 1'b1, exp: mk(0, 0, 1, 1, 1, 0, 1, 1)};
        tbl[2] = '{pen: 1'b0, exp: mk(0, 0, 1, 1, 1, 0, 0, 0)};
        tbl[3] = '{pen: 1'b1, exp: mk(1, 0, 1, 1, 1, 0, 0, 0)};
        tbl[4] = '{pen: 1'b1, exp: mk(2, 0, 1, 1, 1, 0, 0, 0)};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", sample(), mk(HT - 1, VT - 1, 1, 1, 0, 0, 0, 0));
        rst = 1'b1;

        // table-driven start-up sequence
        for (int i = 0; i < 5; i++) tick_exp("table", tbl[i].pen, tbl[i].exp);

        // restart with the model tracking, window 10,5 size 4x3
        rst = 1'b0;
        #1;
        check("reset_again", sample(), mk(HT - 1, VT - 1, 1, 1, 0, 0, 0, 0));
        model_reset();
        win_x = 10; win_y = 5; win_w = 4; win_h = 3;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick("first_frame_start", 1'b1);
        run_frame("frame_a", 12, -1, '0);
        run_frame("frame_midchg", 12, 500, PW'(20));
        run_frame("frame_newx", 12, -1, '0);

        // sparse enable: one step every 4th clk
        nls = 0; nfs = 0;
        for (int i = 0; i < HT * VT + 4 * HT; i++) begin
            tick("sparse", 1'b1);
            if (last.ls) nls++;
            if (last.fs) nfs++;
            for (int g = 0; g < 3; g++) begin
                tick("sparse_gap", 1'b0);
                if (last.ls) nls++;
                if (last.fs) nfs++;
            end
        end
        check_int("sparse_line_starts", nls, VT + 4);
        check_int("sparse_frame_starts", nfs, 1);

        // clipping window at right edge and bottom
        win_x = 30; win_y = 18; win_w = 8; win_h = 5;
        guard = 0;
        do begin
            tick("seek_fs", 1'b1);
            guard++;
        end while (!last.fs && guard < HT * VT + 2);
        check_int("seek_fs_found", int'(last.fs), 1);
        run_frame("frame_clip", 4, -1, '0);

        // asynchronous reset mid-frame
        win_x = 10; win_y = 5; win_w = 4; win_h = 3;
        guard = 0;
        while (!(mx == 20 && my == 10) && guard < HT * VT + 2) begin
            tick("seek_pos", 1'b1);
            guard++;
        end
        check_int("seek_pos_found", int'(mx == 20 && my == 10), 1);
        pix_en = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("async_reset", sample(), mk(HT - 1, VT - 1, 1, 1, 0, 0, 0, 0));
        model_reset();
        @(posedge clk);
        #1;
        check("reset_hold", sample(), mk(HT - 1, VT - 1, 1, 1, 0, 0, 0, 0));
        rst = 1'b1;
        tick("post_reset_first", 1'b1);
        check_int("post_reset_fs", int'(last.fs), 1);
        check_int("post_reset_inw", int'(last.inw), 0);
        run_frame("frame_post_reset", 12, -1, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the single-axis pixel counter.
- One clock domain with a pixel enable. Generates horizontal and vertical position, h_sync/v_sync, and active-video and line/frame strobes.
- Adds a programmable sprite window hit flag (generalised finder position) for the sprite control path.
- Sits between the clock divider and the sprite/colour mux.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of h_sync/v_sync (0 = active-low)
POS_W, 10, width of position and window buses; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
pix_en  in  1  pixel enable; one pixel step per clk cycle in which it is high
win_x  in  POS_W  sprite window left column
win_y  in  POS_W  sprite window top line
win_w  in  POS_W  sprite window width (0 = disabled)
win_h  in  POS_W  sprite window height (0 = disabled)
h_pos  out  POS_W  current column, 0..H_TOTAL-1
v_pos  out  POS_W  current line, 0..V_TOTAL-1
h_sync  out  1  horizontal sync
v_sync  out  1  vertical sync
active  out  1  high when h_pos<H_ACTIVE and v_pos<V_ACTIVE
in_window  out  1  active and position inside latched window
line_start  out  1  one-clk strobe at h_pos wrap to 0
frame_start  out  1  one-clk strobe at wrap to (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL likewise (525).
- Reset (rst low, async):
  - h_pos=H_TOTAL-1, v_pos=V_TOTAL-1.
  - h_sync=v_sync=~SYNC_POL.
  - active=in_window=line_start=frame_start=0.
  - Latched window cleared to w=h=0.
  - The first pix_en after reset wraps to (0,0) and raises frame_start.
- All outputs are registered and updated on the same edge as the counters, so they always describe the current h_pos/v_pos. There is zero extra pipeline latency.
- pix_en low: counters and all level outputs hold. line_start and frame_start drop to 0.
- Horizontal FSM, derived from h_pos: ACTIVE [0,H_ACTIVE) -> FRONT -> SYNC -> BACK -> ACTIVE.
  - h_pos increments on pix_en and wraps from H_TOTAL-1 to 0.
  - h_sync=SYNC_POL only in SYNC: [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
- Vertical FSM, same four phases:
  - v_pos increments only on the pix_en where h_pos wraps. It wraps from V_TOTAL-1 to 0.
  - v_sync changes only at line boundaries. It is asserted for v_pos in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC).
- Strobes:
  - line_start=1 for exactly one clk, on the edge where h_pos becomes 0.
  - frame_start=1 on the edge where (h_pos,v_pos) becomes (0,0); line_start is also 1 there.
  - If pix_en is sparse, the strobe is still one clk while h_pos holds 0.
- Window latch:
  - win_x/y/w/h are sampled on the frame_start edge only.
  - Mid-frame input changes take effect next frame.
- in_window = active & (x>=wx) & (x<wx+ww) & (y>=wy) & (y<wy+wh).
  - Sums are computed at POS_W+1 bits, so windows extending past the screen edge clip without wrap.
  - ww=0 or wh=0 keeps in_window at 0.
- Reset mid-frame: immediate return to reset values. The window is cleared until the next frame_start latch.

Test Plan:
- Reset, then pix_en=1 continuously:
  - First edge gives h_pos=0, v_pos=0, frame_start=1, line_start=1, active=1.
  - Next edge gives h_pos=1 with both strobes 0.
- Count one line:
  - h_sync goes low at h_pos=656 and returns high at h_pos=752.
  - active falls at h_pos=640.
  - h_pos wraps 799->0 with v_pos 0->1 and line_start=1.
- Full frame (420000 pix_en):
  - v_sync is low exactly for v_pos 490..491.
  - frame_start recurs every 420000 enables.
  - active=0 for all of v_pos>=480.
- pix_en every 4th clk:
  - Positions advance once per 4 clks.
  - line_start and frame_start are high for one clk only.
  - Outputs hold in the gaps.
- Window x=100, y=50, w=16, h=8, latched at frame_start:
  - in_window=1 exactly for x 100..115 and y 50..57 (128 pixels per frame).
  - Changing win_x mid-frame affects the next frame only.
  - x=630, w=32 clips at 639.
- Assert rst at (300,200) with pix_en high: outputs return to reset values asynchronously. After release, the first pix_en gives (0,0) with frame_start=1 and in_window=0.
